// File: rtl/alu_issue_fifo_if.sv
// Request/response bundle between the producer, alu_issue_fifo and the downstream ALU.
// Carries the producer-side request, the ALU-side head entry and the occupancy count.
interface alu_issue_fifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             op_in;
  logic             valid_in;
  logic             ready_out;

  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             op_out;
  logic             valid_out;
  logic             ready_in;

  logic [CNT_W-1:0] count;

  // Handshake: a transfer happens on a posedge where valid and ready are both high.
  // Valid never waits on ready, and a raised valid holds its payload stable until the
  // transfer. The FIFO's ready_out/valid_out come only from registered state.
  modport master (
    output a_in, b_in, op_in, valid_in, ready_in,
    input  ready_out, a_out, b_out, op_out, valid_out, count
  );

  modport slave (
    input  a_in, b_in, op_in, valid_in, ready_in,
    output ready_out, a_out, b_out, op_out, valid_out, count
  );
endinterface

// File: rtl/alu_issue_fifo.sv
// Elastic in-order request queue in front of the ready/valid ALU.
// Holds {op, a, b}; all handshake outputs come from registered state, no bypass path.
module alu_issue_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_issue_fifo_if.slave       bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

  typedef struct packed {
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;

  logic   full;
  logic   empty;
  logic   push;
  logic   pop;
  entry_t wr_entry;
  entry_t head;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // Full refuses the push even when the ALU drains in the same cycle, which keeps
  // ready_in off the combinational cone of ready_out.
  assign push = bus.valid_in && !full;
  assign pop  = !empty && bus.ready_in;

  assign wr_entry = '{op: bus.op_in, a: bus.a_in, b: bus.b_in};
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ONE_PTR;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ONE_PTR;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count_q <= count_q + ONE_CNT;
        2'b01:   count_q <= count_q - ONE_CNT;
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.ready_out = !full;
  assign bus.valid_out = !empty;
  assign bus.a_out     = head.a;
  assign bus.b_out     = head.b;
  assign bus.op_out    = head.op;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_alu_issue_fifo.sv
// Randomised bench for alu_issue_fifo against a queue-based model of an in-order
// bounded buffer; each scenario task does its own inline comparisons.
module tb_alu_issue_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int EW    = 2 * WIDTH + 1;

  logic clk;
  logic reset;

  alu_issue_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  alu_issue_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: expected contents, head first
  logic [EW-1:0] exp_q[$];
  int n_cmp;
  int n_err;
  bit last_push;
  bit last_pop;

  // Advance one clock: the model accepts a request whenever it holds fewer than DEPTH
  // entries and releases its oldest whenever it is non-empty and the ALU is ready.
  task automatic step();
    bit do_push;
    bit do_pop;
    do_push = bus.valid_in && (exp_q.size() < DEPTH);
    do_pop  = (exp_q.size() > 0) && bus.ready_in;
    @(posedge clk);
    if (do_pop) void'(exp_q.pop_front());
    if (do_push) exp_q.push_back({bus.op_in, bus.a_in, bus.b_in});
    last_push = do_push;
    last_pop  = do_pop;
    #1;
  endtask

  task automatic drive_req(input bit v, input logic op, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b);
    bus.valid_in = v;
    bus.op_in    = op;
    bus.a_in     = a;
    bus.b_in     = b;
  endtask

  task automatic test_reset();
    logic [WIDTH-1:0] r;
    reset = 1'b0;
    bus.ready_in = 1'b0;
    drive_req(1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL rst_count got=%0d exp=0", bus.count); end
    n_cmp++; if (bus.valid_out !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", bus.valid_out); end
    n_cmp++; if (bus.ready_out !== 1'b1) begin n_err++; $display("FAIL rst_ready got=%b exp=1", bus.ready_out); end
    n_cmp++; if ({bus.op_out, bus.a_out, bus.b_out} !== '0) begin n_err++; $display("FAIL rst_head got=%h exp=0", {bus.op_out, bus.a_out, bus.b_out}); end
    // fill to three then reset asynchronously between edges
    for (int k = 0; k < 3; k++) begin
      r = $urandom;
      drive_req(1'b1, 1'(k), r, ~r);
      step();
    end
    drive_req(1'b0, 1'b0, '0, '0);
    n_cmp++; if (bus.count !== 3'd3) begin n_err++; $display("FAIL rst_pre_count got=%0d exp=3", bus.count); end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL rst_async_count got=%0d exp=0", bus.count); end
    n_cmp++; if (bus.valid_out !== 1'b0) begin n_err++; $display("FAIL rst_async_valid got=%b exp=0", bus.valid_out); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    n_cmp++; if (bus.ready_out !== 1'b1) begin n_err++; $display("FAIL rst_release_ready got=%b exp=1", bus.ready_out); end
    n_cmp++; if ({bus.op_out, bus.a_out, bus.b_out} !== '0) begin n_err++; $display("FAIL rst_release_head got=%h exp=0", {bus.op_out, bus.a_out, bus.b_out}); end
    step();
    n_cmp++; if (bus.valid_out !== 1'b0) begin n_err++; $display("FAIL rst_nothing_survives got=%b exp=0", bus.valid_out); end
  endtask

  task automatic test_single();
    bus.ready_in = 1'b0;
    drive_req(1'b1, 1'b1, 32'h3F80_0000, 32'h4000_0000);
    step();
    drive_req(1'b0, 1'b0, '0, '0);
    n_cmp++; if (bus.valid_out !== 1'b1) begin n_err++; $display("FAIL single_valid got=%b exp=1", bus.valid_out); end
    n_cmp++; if (bus.count !== 3'd1) begin n_err++; $display("FAIL single_count got=%0d exp=1", bus.count); end
    n_cmp++; if (bus.op_out !== 1'b1) begin n_err++; $display("FAIL single_op got=%b exp=1", bus.op_out); end
    n_cmp++; if (bus.a_out !== 32'h3F80_0000) begin n_err++; $display("FAIL single_a got=%h exp=3f800000", bus.a_out); end
    n_cmp++; if (bus.b_out !== 32'h4000_0000) begin n_err++; $display("FAIL single_b got=%h exp=40000000", bus.b_out); end
    bus.ready_in = 1'b1;
    step();
    bus.ready_in = 1'b0;
    n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL single_pop_count got=%0d exp=0", bus.count); end
    n_cmp++; if (bus.valid_out !== 1'b0) begin n_err++; $display("FAIL single_pop_valid got=%b exp=0", bus.valid_out); end
  endtask

  // Leaves the FIFO full with a fifth request held on the producer side.
  logic [EW-1:0] fill_ent [5];

  task automatic test_fill();
    bus.ready_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      fill_ent[k] = {1'($urandom), 32'($urandom), 32'($urandom)};
      drive_req(1'b1, fill_ent[k][EW-1], fill_ent[k][2*WIDTH-1:WIDTH], fill_ent[k][WIDTH-1:0]);
      step();
      n_cmp++; if (int'(bus.count) != ((k < 4) ? k + 1 : 4)) begin n_err++; $display("FAIL fill_count_%0d got=%0d exp=%0d", k, bus.count, (k < 4) ? k + 1 : 4); end
    end
    n_cmp++; if (bus.ready_out !== 1'b0) begin n_err++; $display("FAIL fill_ready got=%b exp=0", bus.ready_out); end
    n_cmp++; if ({bus.op_out, bus.a_out, bus.b_out} !== fill_ent[0]) begin n_err++; $display("FAIL fill_head got=%h exp=%h", {bus.op_out, bus.a_out, bus.b_out}, fill_ent[0]); end
  endtask

  task automatic test_full_pop_push();
    int guard;
    bus.ready_in = 1'b1;
    step();
    n_cmp++; if (last_push !== 1'b0 || bus.count !== 3'd3) begin n_err++; $display("FAIL fullpp_count got=%0d exp=3", bus.count); end
    n_cmp++; if (bus.ready_out !== 1'b1) begin n_err++; $display("FAIL fullpp_ready got=%b exp=1", bus.ready_out); end
    n_cmp++; if ({bus.op_out, bus.a_out, bus.b_out} !== fill_ent[1]) begin n_err++; $display("FAIL fullpp_head got=%h exp=%h", {bus.op_out, bus.a_out, bus.b_out}, fill_ent[1]); end
    bus.ready_in = 1'b0;
    step();
    n_cmp++; if (bus.count !== 3'd4) begin n_err++; $display("FAIL fullpp_refill got=%0d exp=4", bus.count); end
    drive_req(1'b0, 1'b0, '0, '0);
    bus.ready_in = 1'b1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      n_cmp++; if ({bus.op_out, bus.a_out, bus.b_out} !== exp_q[0]) begin n_err++; $display("FAIL drain_head got=%h exp=%h", {bus.op_out, bus.a_out, bus.b_out}, exp_q[0]); end
      step();
      guard++;
    end
    n_cmp++; if (bus.valid_out !== 1'b0 || bus.count !== 3'd0) begin n_err++; $display("FAIL drain_empty got=%b/%0d exp=0/0", bus.valid_out, bus.count); end
    bus.ready_in = 1'b0;
  endtask

  task automatic test_streaming();
    int i;
    logic [WIDTH-1:0] got[$];
    i = 0;
    bus.ready_in = 1'b1;
    for (int cyc = 0; cyc < 25; cyc++) begin
      drive_req(i < 20, 1'($urandom), WIDTH'(i), 32'($urandom));
      if (bus.valid_out && bus.ready_in) got.push_back(bus.a_out);
      step();
      if (last_push) i++;
      n_cmp++; if (bus.count > 3'd1) begin n_err++; $display("FAIL stream_count cyc=%0d got=%0d exp<=1", cyc, bus.count); end
    end
    drive_req(1'b0, 1'b0, '0, '0);
    n_cmp++; if (got.size() != 20) begin n_err++; $display("FAIL stream_total got=%0d exp=20", got.size()); end
    for (int k = 0; k < got.size() && k < 20; k++) begin
      n_cmp++; if (got[k] !== WIDTH'(k)) begin n_err++; $display("FAIL stream_order k=%0d got=%0d exp=%0d", k, got[k], k); end
    end
    bus.ready_in = 1'b0;
  endtask

  task automatic test_back_pressure();
    int pops;
    int cyc;
    bit hold_chk;
    logic [EW-1:0] held;
    pops = 0;
    cyc  = 0;
    drive_req(1'b0, 1'b0, '0, '0);
    while (pops < 1000 && cyc < 20000) begin
      if (!bus.valid_in || last_push)
        drive_req($urandom_range(0, 3) != 0, 1'($urandom), 32'($urandom), 32'($urandom));
      bus.ready_in = ($urandom_range(0, 2) != 0);
      hold_chk = bus.valid_out && !bus.ready_in;
      held = {bus.op_out, bus.a_out, bus.b_out};
      step();
      cyc++;
      if (last_pop) pops++;
      n_cmp++; if (int'(bus.count) != exp_q.size()) begin n_err++; $display("FAIL bp_count cyc=%0d got=%0d exp=%0d", cyc, bus.count, exp_q.size()); end
      n_cmp++; if (bus.valid_out !== (exp_q.size() > 0)) begin n_err++; $display("FAIL bp_valid cyc=%0d got=%b exp=%b", cyc, bus.valid_out, exp_q.size() > 0); end
      n_cmp++; if (bus.ready_out !== (exp_q.size() < DEPTH)) begin n_err++; $display("FAIL bp_ready cyc=%0d got=%b exp=%b", cyc, bus.ready_out, exp_q.size() < DEPTH); end
      if (exp_q.size() > 0) begin
        n_cmp++; if ({bus.op_out, bus.a_out, bus.b_out} !== exp_q[0]) begin n_err++; $display("FAIL bp_head cyc=%0d got=%h exp=%h", cyc, {bus.op_out, bus.a_out, bus.b_out}, exp_q[0]); end
      end
      if (hold_chk) begin
        n_cmp++; if ({bus.op_out, bus.a_out, bus.b_out} !== held) begin n_err++; $display("FAIL bp_stable cyc=%0d got=%h exp=%h", cyc, {bus.op_out, bus.a_out, bus.b_out}, held); end
      end
    end
    n_cmp++; if (pops < 1000) begin n_err++; $display("FAIL bp_timeout got=%0d exp=1000 pops", pops); end
    drive_req(1'b0, 1'b0, '0, '0);
    bus.ready_in = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    last_push = 1'b0;
    last_pop  = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_full_pop_push();
    test_streaming();
    test_back_pressure();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
